bit_invert_pipe: RTL and testbench

Parametrised, elastic successor to the single-bit inverter: accepts WIDTH-bit words over a valid/ready handshake, inverts the bits selected by a per-word mask, and delivers the result after a configurable number of register stages. Sits between a producer and a consumer on the datapath wherever a registered, back-pressure-aware polarity correction is needed. An optional redundant copy of the datapath compares both results every cycle and raises a sticky mismatch flag for on-line equivalence checking.

---
 rtl/bit_invert_pkg.sv | 8 +
 rtl/bit_invert_stage.sv | 29 ++
 rtl/bit_invert_pipe.sv | 127 ++++++++++++
 tb/tb_bit_invert_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_invert_pkg.sv
// Shared constants and types for the bit_invert_pipe slice.
package bit_invert_pkg;
  localparam int DEF_WIDTH  = 2;
  localparam int DEF_STAGES = 2;
  localparam int DEF_CNT_W  = 16;

  typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/bit_invert_stage.sv
// One elastic register stage: loads the upstream word whenever its ready term is high.
module bit_invert_stage
  import bit_invert_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  // Data holds when no word arrives so a bubble never overwrites the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (rdy) begin
      vld <= up_valid;
      if (up_valid) begin
        dat <= up_data;
      end
    end
  end

endmodule

// File: rtl/bit_invert_pipe.sv
// Elastic masked-inversion pipeline of STAGES register stages with an output word counter.
// Define BIT_INVERT_PIPE_LOCKSTEP_EN to add a redundant datapath copy and sticky mismatch flag.
module bit_invert_pipe
  import bit_invert_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             mismatch
);

  // Handshake: a word moves across a port on a rising edge where valid and ready
  // are both 1; stage k is ready when empty or when stage k+1 is ready.
  logic [WIDTH-1:0] in_word;
  logic [STAGES-1:0] p_vld;
  logic [WIDTH-1:0]  p_dat [STAGES];
  logic [STAGES:0]   p_rdy;

  assign in_word = in_data ^ in_mask;

  always_comb begin
    p_rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      p_rdy[k] = !p_vld[k] || p_rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_pri
    if (k == 0) begin : g_first
      bit_invert_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .rdy      (p_rdy[0]),
        .up_valid (in_valid),
        .up_data  (in_word),
        .vld      (p_vld[0]),
        .dat      (p_dat[0])
      );
    end else begin : g_rest
      bit_invert_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .rdy      (p_rdy[k]),
        .up_valid (p_vld[k-1]),
        .up_data  (p_dat[k-1]),
        .vld      (p_vld[k]),
        .dat      (p_dat[k])
      );
    end
  end

  assign in_ready  = p_rdy[0];
  assign out_valid = p_vld[STAGES-1];
  assign out_data  = p_dat[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

`ifdef BIT_INVERT_PIPE_LOCKSTEP_EN
  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_dat [STAGES];
  logic [STAGES:0]   r_rdy;
  logic              mm_q;

  // The redundant copy runs its own ready chain so a fault there stays independent.
  always_comb begin
    r_rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r_rdy[k] = !r_vld[k] || r_rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_red
    if (k == 0) begin : g_first
      bit_invert_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .rdy      (r_rdy[0]),
        .up_valid (in_valid),
        .up_data  (in_word),
        .vld      (r_vld[0]),
        .dat      (r_dat[0])
      );
    end else begin : g_rest
      bit_invert_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .rdy      (r_rdy[k]),
        .up_valid (r_vld[k-1]),
        .up_data  (r_dat[k-1]),
        .vld      (r_vld[k]),
        .dat      (r_dat[k])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mm_q <= 1'b0;
    end else if ((p_vld[STAGES-1] != r_vld[STAGES-1]) ||
                 (p_vld[STAGES-1] && (p_dat[STAGES-1] != r_dat[STAGES-1]))) begin
      mm_q <= 1'b1;
    end
  end

  assign mismatch = mm_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_bit_invert_pipe.sv
// Randomized and directed bench for bit_invert_pipe against an in-order queue model.
module tb_bit_invert_pipe;
  localparam int W = 2;
  localparam int S = 2;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] in_mask = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [C-1:0] out_count;
  logic         mismatch;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit checking = 1'b0;
  bit rand_out = 1'b0;
  bit mm_exp   = 1'b0;

  logic [W-1:0] exp_q[$];
  int           t_q[$];
  logic [C-1:0] cnt_m = '0;

  bit_invert_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .mismatch  (mismatch)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // scoreboard: words leave in order, each STAGES edges after acceptance at the earliest
  always @(negedge clk) begin
    bit vexp;
    bit rexp;
    vexp = (exp_q.size() > 0) && (cyc >= t_q[0] + S - 1);
    rexp = (exp_q.size() < S) || out_ready;
    if (checking) begin
      check("out_valid", out_valid, vexp);
      if (vexp) check("out_data", out_data, exp_q[0]);
      check("in_ready", in_ready, rexp);
      check("out_count", out_count, cnt_m);
      check("mismatch", mismatch, mm_exp);
    end
    if (rst) begin
      exp_q.delete();
      t_q.delete();
      cnt_m = '0;
      mm_exp = 1'b0;
    end else begin
      if (vexp && out_ready) begin
        void'(exp_q.pop_front());
        void'(t_q.pop_front());
        cnt_m = cnt_m + C'(1);
      end
      if (in_valid && rexp) begin
        exp_q.push_back(in_data ^ in_mask);
        t_q.push_back(cyc + 1);
      end
    end
  end

  // driver tasks
  always begin
    @(posedge clk);
    #1;
    if (rand_out) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] m);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mismatch", mismatch, 0);
    @(posedge clk);
    #1;

    // single word, latency pinned by hand
    out_ready = 1'b1;
    send(2'b01, 2'b11);
    @(negedge clk);
    check("lat_early_valid", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 2'b10);
    @(negedge clk);
    check("lat_count", out_count, 1);
    @(posedge clk);
    #1;

    // mask patterns
    send(2'b11, 2'b00);
    send(2'b11, 2'b10);
    @(negedge clk);
    check("mask00_data", out_data, 2'b11);
    @(negedge clk);
    check("mask10_data", out_data, 2'b01);
    repeat (3) @(posedge clk);
    #1;

    // back-to-back stream
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(W'($urandom_range(0, 3)), W'($urandom_range(0, 3)));
    check("stream_cycles", cyc - c0, 8);
    repeat (4) @(posedge clk);
    #1;

    // fill with back-pressure, then drain
    out_ready = 1'b0;
    send(2'b00, 2'b01);
    send(2'b11, 2'b01);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_out_data", out_data, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_data", out_data, 2'b01);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_first", out_data, 2'b01);
    @(negedge clk);
    check("drain_second", out_data, 2'b10);
    @(negedge clk);
    check("drain_empty_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // counter wrap with CNT_W = 4
    pulse_reset();
    for (int i = 0; i < 17; i++) send(W'($urandom_range(0, 3)), W'($urandom_range(0, 3)));
    repeat (S + 1) @(negedge clk);
    check("wrap_count", out_count, 1);
    @(posedge clk);
    #1;

    // random traffic with random back-pressure
    rand_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 1) != 0);
      in_data  = W'($urandom_range(0, 3));
      in_mask  = W'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rand_out = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("random_drained", exp_q.size(), 0);

`ifdef BIT_INVERT_PIPE_LOCKSTEP_EN
    force dut.g_red[1].g_rest.u_stage.vld = 1'b1;
    @(posedge clk);
    #1;
    mm_exp = 1'b1;
    release dut.g_red[1].g_rest.u_stage.vld;
    repeat (3) @(negedge clk);
    check("lockstep_sticky", mismatch, 1);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("lockstep_cleared", mismatch, 0);
    @(posedge clk);
    #1;
`endif

    // reset in the middle of a stream
    send(2'b01, 2'b00);
    send(2'b10, 2'b01);
    send(2'b11, 2'b11);
    in_valid = 1'b1;
    in_data  = 2'b00;
    in_mask  = 2'b11;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_count", out_count, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    check("midrst_no_ghost", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
